// File: rtl/ref_mem_pkg.sv
// Shared reference-memory constants, arbiter state encoding and bank/address helpers.
// Used by the refill arbiter and by the read address sequencer.
package ref_mem_pkg;

    localparam int NUM_BANKS = 32;
    localparam int GRP_BANKS = 4;
    localparam int ADDR_W    = 7;
    localparam int NUM_GRPS  = NUM_BANKS / GRP_BANKS;
    localparam int GRP_W     = $clog2(NUM_GRPS);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_FORCE = 1'b1
    } arb_state_e;

    // Bank enables for group g: banks GRP_BANKS*g .. GRP_BANKS*g+GRP_BANKS-1.
    function automatic logic [NUM_BANKS-1:0] grp_mask(input logic [GRP_W-1:0] g);
        logic [NUM_BANKS-1:0] base;
        base = NUM_BANKS'({GRP_BANKS{1'b1}});
        return base << (GRP_BANKS * int'(g));
    endfunction

    // Places addr in every selected bank's slot; unselected slots read as 0.
    function automatic logic [ADDR_W*NUM_BANKS-1:0] pack_addr_slots(
        input logic [NUM_BANKS-1:0] sel,
        input logic [ADDR_W-1:0]    addr
    );
        logic [ADDR_W*NUM_BANKS-1:0] slots;
        slots = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (sel[i]) slots[i*ADDR_W +: ADDR_W] = addr;
        end
        return slots;
    endfunction

endpackage

// File: rtl/ref_refill_fifo.sv
// Register-based synchronous FIFO holding queued refill beats {group, addr, data}.
// DEPTH must be a power of two so the pointers wrap without compare logic.
module ref_refill_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 din_i,
    output logic [W-1:0]                 dout_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Storage needs no reset: an entry is only read once level says it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ref_bank_refill_arb.sv
// Arbitrates the single-port reference banks between the read sequencer (priority)
// and queued refill writes, with a one-slot read stall to bound write starvation.
module ref_bank_refill_arb
    import ref_mem_pkg::*;
#(
    parameter int DATA_W       = 256,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_req_valid,
    output logic                              wr_req_ready,
    input  logic [GRP_W-1:0]                  wr_req_group,
    input  logic [ADDR_W-1:0]                 wr_req_addr,
    input  logic [DATA_W-1:0]                 wr_req_data,
    input  logic [NUM_BANKS-1:0]              rd_bank_busy,
    output logic                              rd_stall,
    output logic [NUM_BANKS-1:0]              Bank_sel,
    output logic [ADDR_W*NUM_BANKS-1:0]       write_address_all,
    output logic [DATA_W-1:0]                 wr_data_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   queue_level,
    output logic [9:0]                        wr_commit_cnt
);

    localparam int ENT_W = GRP_W + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [ENT_W-1:0]     head;
    logic [GRP_W-1:0]     head_grp;
    logic [ADDR_W-1:0]    head_addr;
    logic [DATA_W-1:0]    head_data;
    logic [NUM_BANKS-1:0] head_mask;
    logic                 fifo_full, fifo_empty;
    logic                 head_valid, grant, push;

    arb_state_e                  state_q;
    logic [CNT_W-1:0]            starve_q;
    logic                        rd_stall_q;
    logic [NUM_BANKS-1:0]        bank_sel_q;
    logic [ADDR_W*NUM_BANKS-1:0] addr_all_q;
    logic [DATA_W-1:0]           wr_data_q;
    logic [9:0]                  commit_q;

    // Ready depends only on the registered level, so a full queue never pushes and pops together.
    assign wr_req_ready = ~fifo_full;
    assign push         = wr_req_valid & wr_req_ready;

    ref_refill_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (grant),
        .din_i   ({wr_req_group, wr_req_addr, wr_req_data}),
        .dout_o  (head),
        .level_o (queue_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_grp, head_addr, head_data} = head;
    assign head_valid = ~fifo_empty;
    assign head_mask  = grp_mask(head_grp);
    // In FORCE the reader has been told to stay off the memory, so busy is ignored.
    assign grant      = head_valid &&
                        (state_q == ST_FORCE || (rd_bank_busy & head_mask) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            starve_q   <= '0;
            rd_stall_q <= 1'b0;
            bank_sel_q <= '0;
            addr_all_q <= '0;
            wr_data_q  <= '0;
            commit_q   <= '0;
        end else begin
            if (grant) begin
                bank_sel_q <= head_mask;
                addr_all_q <= pack_addr_slots(head_mask, head_addr);
                wr_data_q  <= head_data;
                commit_q   <= commit_q + 10'd1;
            end else begin
                bank_sel_q <= '0;
                addr_all_q <= '0;
            end

            case (state_q)
                ST_ARB: begin
                    if (!head_valid || grant) begin
                        starve_q <= '0;
                    end else if (starve_q == CNT_W'(STARVE_LIMIT)) begin
                        state_q    <= ST_FORCE;
                        rd_stall_q <= 1'b1;
                    end else begin
                        starve_q <= starve_q + CNT_W'(1);
                    end
                end
                ST_FORCE: begin
                    starve_q   <= '0;
                    state_q    <= ST_ARB;
                    rd_stall_q <= 1'b0;
                end
                default: begin
                    state_q    <= ST_ARB;
                    rd_stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_stall          = rd_stall_q;
    assign Bank_sel          = bank_sel_q;
    assign write_address_all = addr_all_q;
    assign wr_data_o         = wr_data_q;
    assign wr_commit_cnt     = commit_q;

endmodule

// File: tb/tb_ref_bank_refill_arb.sv
// Randomized and directed bench for ref_bank_refill_arb against a queue-based reference model.
module tb_ref_bank_refill_arb;

    localparam int STARVE = 16;
    localparam int DEPTH  = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_req_valid;
    logic         wr_req_ready;
    logic [2:0]   wr_req_group;
    logic [6:0]   wr_req_addr;
    logic [255:0] wr_req_data;
    logic [31:0]  rd_bank_busy;
    logic         rd_stall;
    logic [31:0]  Bank_sel;
    logic [223:0] write_address_all;
    logic [255:0] wr_data_o;
    logic [2:0]   queue_level;
    logic [9:0]   wr_commit_cnt;

    ref_bank_refill_arb dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wr_req_valid      (wr_req_valid),
        .wr_req_ready      (wr_req_ready),
        .wr_req_group      (wr_req_group),
        .wr_req_addr       (wr_req_addr),
        .wr_req_data       (wr_req_data),
        .rd_bank_busy      (rd_bank_busy),
        .rd_stall          (rd_stall),
        .Bank_sel          (Bank_sel),
        .write_address_all (write_address_all),
        .wr_data_o         (wr_data_o),
        .queue_level       (queue_level),
        .wr_commit_cnt     (wr_commit_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: queued beats plus a run-length of consecutive blocked cycles.
    typedef struct {
        logic [2:0]   g;
        logic [6:0]   a;
        logic [255:0] d;
    } beat_t;

    beat_t        mq[$];
    int           m_run;
    bit           m_force;
    logic [31:0]  e_sel;
    logic [223:0] e_addr;
    logic [255:0] e_data;
    logic [9:0]   e_cnt;
    bit           e_stall;

    task automatic model_reset();
        mq.delete();
        m_run   = 0;
        m_force = 0;
        e_sel   = '0;
        e_addr  = '0;
        e_data  = '0;
        e_cnt   = '0;
        e_stall = 0;
    endtask

    function automatic logic [31:0] gmask(input logic [2:0] g);
        logic [31:0] m;
        m = 32'h0000_000F;
        return m << (4 * int'(g));
    endfunction

    task automatic model_step(input bit v, input beat_t b, input logic [31:0] busy);
        int          sz;
        bit          gr;
        bit          nxt;
        logic [31:0] m;
        sz = mq.size();
        gr = 0;
        m  = '0;
        if (sz > 0) begin
            m  = gmask(mq[0].g);
            gr = m_force || ((busy & m) == 32'd0);
        end
        if (gr) begin
            e_sel  = m;
            e_addr = '0;
            for (int k = 0; k < 4; k++) e_addr[(4*int'(mq[0].g)+k)*7 +: 7] = mq[0].a;
            e_data = mq[0].d;
            e_cnt  = e_cnt + 10'd1;
            void'(mq.pop_front());
        end else begin
            e_sel  = '0;
            e_addr = '0;
        end
        nxt = 0;
        if (m_force || sz == 0 || gr) m_run = 0;
        else begin
            m_run++;
            nxt = (m_run > STARVE);
        end
        m_force = nxt;
        e_stall = nxt;
        if (v && sz < DEPTH) mq.push_back(b);
    endtask

    task automatic check_all();
        chk("bank_sel", Bank_sel, e_sel);
        chk("addr_all", write_address_all, e_addr);
        chk("wr_data", wr_data_o, e_data);
        chk("commit", wr_commit_cnt, e_cnt);
        chk("rd_stall", rd_stall, e_stall);
        chk("level", queue_level, mq.size());
        chk("ready", wr_req_ready, mq.size() < DEPTH);
    endtask

    task automatic cycle(input bit v, input logic [2:0] g, input logic [6:0] a,
                         input logic [255:0] d, input logic [31:0] busy);
        beat_t b;
        b.g = g; b.a = a; b.d = d;
        wr_req_valid = v;
        wr_req_group = g;
        wr_req_addr  = a;
        wr_req_data  = d;
        rd_bank_busy = busy;
        model_step(v, b, busy);
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [255:0] rdata();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic idle(input logic [31:0] busy);
        cycle(1'b0, 3'd0, 7'd0, '0, busy);
    endtask

    initial begin
        int           stalls, wr7, guard, mode;
        logic [31:0]  busy;
        logic [2:0]   gl [4];
        gl[0] = 3'd3; gl[1] = 3'd1; gl[2] = 3'd6; gl[3] = 3'd0;

        rst_n = 1'b0;
        wr_req_valid = 1'b0; wr_req_group = '0; wr_req_addr = '0;
        wr_req_data = '0; rd_bank_busy = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", Bank_sel, 32'd0);
        chk("rst_ready", wr_req_ready, 1'b1);
        chk("rst_level", queue_level, 3'd0);
        chk("rst_stall", rd_stall, 1'b0);
        chk("rst_cnt", wr_commit_cnt, 10'd0);
        chk("rst_data", wr_data_o, 256'd0);
        rst_n = 1'b1;

        // Write with reader idle: visible two cycles after the push.
        cycle(1'b1, 3'd2, 7'h05, rdata(), 32'd0);
        chk("idle_not_early", Bank_sel, 32'd0);
        idle(32'd0);
        chk("idle_sel", Bank_sel, 32'h0000_0F00);
        chk("idle_slot9", write_address_all[9*7 +: 7], 7'h05);
        chk("idle_cnt", wr_commit_cnt, 10'd1);

        // Write deferred while the reader holds group 0.
        cycle(1'b1, 3'd0, 7'h2A, rdata(), 32'h0000_000F);
        idle(32'h0000_000F);
        idle(32'h0000_000F);
        chk("defer_held", Bank_sel, 32'd0);
        idle(32'd0);
        chk("defer_sel", Bank_sel, 32'h0000_000F);

        // Starvation: reader owns every bank permanently.
        stalls = 0; wr7 = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 3'd7, 7'($urandom()), rdata(), 32'hFFFF_FFFF);
            if (rd_stall) stalls++;
            if (Bank_sel == 32'hF000_0000) wr7++;
        end
        for (int i = 0; i < 70; i++) begin
            idle(32'hFFFF_FFFF);
            if (rd_stall) stalls++;
            if (Bank_sel == 32'hF000_0000) wr7++;
        end
        chk("starve_pulses", stalls, 3);
        chk("starve_writes", wr7, 3);

        // Full queue, then drain in push order.
        for (int i = 0; i < 4; i++) cycle(1'b1, gl[i], 7'(i + 1), rdata(), 32'hFFFF_FFFF);
        chk("full_level", queue_level, 3'd4);
        chk("full_ready", wr_req_ready, 1'b0);
        cycle(1'b1, 3'd5, 7'h7F, rdata(), 32'hFFFF_FFFF);
        chk("full_reject", queue_level, 3'd4);
        for (int i = 0; i < 4; i++) begin
            idle(32'd0);
            chk("drain_order", Bank_sel, gmask(gl[i]));
        end
        idle(32'd0);
        chk("drain_empty", queue_level, 3'd0);

        // Randomized traffic with busy patterns held for short phases.
        mode = 0;
        busy = '0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 40 == 0) mode = int'($urandom_range(0, 3));
            case (mode)
                0:       busy = 32'd0;
                1:       busy = 32'hFFFF_FFFF;
                2:       busy = $urandom();
                default: busy = gmask(3'($urandom()));
            endcase
            cycle(($urandom() % 3) != 0, 3'($urandom()), 7'($urandom()), rdata(), busy);
        end
        for (int i = 0; i < 8; i++) idle(32'd0);

        // Reset in FORCE with three beats queued.
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'(i + 2), 7'(i), rdata(), 32'hFFFF_FFFF);
        guard = 0;
        while (!rd_stall && guard < 60) begin
            idle(32'hFFFF_FFFF);
            guard++;
        end
        chk("force_reached", rd_stall, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_sel", Bank_sel, 32'd0);
        chk("mid_rst_stall", rd_stall, 1'b0);
        chk("mid_rst_level", queue_level, 3'd0);
        chk("mid_rst_ready", wr_req_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle(32'd0);
            chk("mid_rst_nowrite", Bank_sel, 32'd0);
        end

        // Commit counter wrap after 1024 granted writes.
        for (int i = 0; i < 1024; i++) cycle(1'b1, 3'($urandom()), 7'($urandom()), rdata(), 32'd0);
        for (int i = 0; i < 3; i++) idle(32'd0);
        chk("wrap_cnt", wr_commit_cnt, 10'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
